// File: rtl/msb_scan_filter_pkg.sv
// Shared sizing for the sorting engine: batch size, index width and element width.
package msb_scan_filter_pkg;

  localparam int ELEMENT_NUM      = 16;
  localparam int LOG2_ELEMENT_NUM = 4;
  localparam int DATA_WIDTH       = 8;
  localparam int BIT_IDX_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

endpackage

// File: rtl/lowest_one_isolate.sv
// Keeps only the lowest set bit of a vector; zero in gives zero out.
module lowest_one_isolate #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] v,
  output logic [WIDTH-1:0] out
);

  // Two's-complement trick: v & -v leaves the least significant one.
  always_comb begin
    out = v & (~v + WIDTH'(1));
  end

endmodule

// File: rtl/msb_scan_filter.sv
// Loads a batch of unsigned elements and repeatedly finds the largest remaining
// one by scanning bit columns MSB to LSB over a shrinking candidate mask. Each
// winner is presented as a one-hot select plus its value, largest first.
module msb_scan_filter
  import msb_scan_filter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   fo_valid,
  input  logic                   fo_ready,
  output logic [ELEMENT_NUM-1:0] one_hot_FO,
  output logic [DATA_WIDTH-1:0]  fo_data,
  output logic                   fo_last,
  output logic                   busy
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0]       elem [ELEMENT_NUM];
  logic [LOG2_ELEMENT_NUM-1:0] wr_ptr;
  logic [LOG2_ELEMENT_NUM-1:0] out_cnt;
  logic [ELEMENT_NUM-1:0]      alive;
  logic [ELEMENT_NUM-1:0]      cand;
  logic [BIT_IDX_W-1:0]        bit_idx;

  logic [ELEMENT_NUM-1:0]      col;
  logic [ELEMENT_NUM-1:0]      final_v;
  logic [ELEMENT_NUM-1:0]      pick;
  logic [ELEMENT_NUM-1:0]      alive_next;
  logic [DATA_WIDTH-1:0]       pick_data;
  logic                        load_accept;
  logic                        last_load;
  logic                        scan_done;
  logic                        out_hs;

  assign load_accept = in_valid & in_ready;
  assign last_load   = load_accept && (wr_ptr == LOG2_ELEMENT_NUM'(ELEMENT_NUM - 1));
  assign scan_done   = (state == ST_SCAN) && (bit_idx == '0);
  assign out_hs      = fo_valid & fo_ready;
  assign alive_next  = alive & ~one_hot_FO;

  // Current bit column of every candidate, and the surviving set after this column.
  always_comb begin
    col = '0;
    for (int i = 0; i < ELEMENT_NUM; i++) begin
      col[i] = cand[i] & elem[i][bit_idx];
    end
    final_v = (col != '0) ? col : cand;
  end

  // Equal maxima survive together; taking the lowest index keeps the select one-hot.
  lowest_one_isolate #(
    .WIDTH (ELEMENT_NUM)
  ) u_tie_break (
    .v   (final_v),
    .out (pick)
  );

  // AND-OR mux of the winning element's value (pick is one-hot).
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < ELEMENT_NUM; i++) begin
      pick_data = pick_data | (elem[i] & {DATA_WIDTH{pick[i]}});
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:    if (last_load) state_nxt = ST_SCAN;
      ST_SCAN:    if (scan_done) state_nxt = ST_PRESENT;
      ST_PRESENT: if (fo_ready)  state_nxt = fo_last ? ST_LOAD : ST_SCAN;
      default:    state_nxt = ST_LOAD;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    in_ready = (state == ST_LOAD);
    fo_valid = (state == ST_PRESENT);
    busy     = (state == ST_SCAN) || (state == ST_PRESENT);
  end

  // Element storage; contents are only meaningful after a full load.
  always_ff @(posedge clk) begin
    if (load_accept) elem[wr_ptr] <= in_data;
  end

  // Load pointer, alive/candidate masks, bit counter and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      out_cnt    <= '0;
      alive      <= '0;
      cand       <= '0;
      bit_idx    <= BIT_IDX_W'(DATA_WIDTH - 1);
      one_hot_FO <= '0;
      fo_data    <= '0;
      fo_last    <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (load_accept) wr_ptr <= wr_ptr + LOG2_ELEMENT_NUM'(1);
          if (last_load) begin
            wr_ptr  <= '0;
            alive   <= '1;
            cand    <= '1;
            bit_idx <= BIT_IDX_W'(DATA_WIDTH - 1);
            out_cnt <= '0;
          end
        end
        ST_SCAN: begin
          cand    <= final_v;
          bit_idx <= bit_idx - BIT_IDX_W'(1);
          if (scan_done) begin
            one_hot_FO <= pick;
            fo_data    <= pick_data;
            fo_last    <= (out_cnt == LOG2_ELEMENT_NUM'(ELEMENT_NUM - 1));
          end
        end
        ST_PRESENT: begin
          if (fo_ready) begin
            out_cnt    <= out_cnt + LOG2_ELEMENT_NUM'(1);
            one_hot_FO <= '0;
            fo_last    <= 1'b0;
            bit_idx    <= BIT_IDX_W'(DATA_WIDTH - 1);
            if (fo_last) begin
              alive <= '0;
              cand  <= '0;
            end else begin
              alive <= alive_next;
              cand  <= alive_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_msb_scan_filter.sv
// Bench for msb_scan_filter: loads batches and checks the emitted order,
// values, last flag, latency and handshake behaviour against a sort model.
module tb_msb_scan_filter;

  localparam int N = 16;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         fo_valid;
  logic         fo_ready;
  logic [N-1:0] one_hot_FO;
  logic [W-1:0] fo_data;
  logic         fo_last;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] batch [N];
  int           order [N];

  msb_scan_filter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .fo_valid   (fo_valid),
    .fo_ready   (fo_ready),
    .one_hot_FO (one_hot_FO),
    .fo_data    (fo_data),
    .fo_last    (fo_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: repeatedly take the largest remaining value, lowest index on ties.
  function automatic void compute_order();
    bit taken [N];
    int best;
    for (int i = 0; i < N; i++) taken[i] = 1'b0;
    for (int k = 0; k < N; k++) begin
      best = -1;
      for (int i = 0; i < N; i++)
        if (!taken[i] && (best < 0 || batch[i] > batch[best])) best = i;
      taken[best] = 1'b1;
      order[k] = best;
    end
  endfunction

  task automatic load_batch(input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_data  = W'($urandom);
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = batch[i];
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready beat %0d: in_ready=%b expected 1", i, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    compute_order();
  endtask

  task automatic drain(input int k0, input int k1);
    int cnt;
    int idx;
    logic [N-1:0] exp_oh;
    fo_ready = 1'b1;
    for (int k = k0; k < k1; k++) begin
      cnt = 0;
      while (fo_valid !== 1'b1 && cnt < 40) begin
        @(posedge clk); #1;
        cnt++;
      end
      idx    = order[k];
      exp_oh = N'(1) << idx;
      checks++;
      if (cnt != W) begin
        errors++;
        $display("FAIL latency out %0d: %0d edges expected %0d", k, cnt, W);
      end
      checks++;
      if (one_hot_FO !== exp_oh) begin
        errors++;
        $display("FAIL one_hot out %0d: got %h expected %h", k, one_hot_FO, exp_oh);
      end
      checks++;
      if (fo_data !== batch[idx]) begin
        errors++;
        $display("FAIL fo_data out %0d: got %0d expected %0d", k, fo_data, batch[idx]);
      end
      checks++;
      if (fo_last !== (k == N - 1)) begin
        errors++;
        $display("FAIL fo_last out %0d: got %b expected %b", k, fo_last, (k == N - 1));
      end
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL present_status out %0d: in_ready=%b busy=%b expected 0/1", k, in_ready, busy);
      end
      @(posedge clk); #1;
      checks++;
      if (fo_valid !== 1'b0 || one_hot_FO !== '0) begin
        errors++;
        $display("FAIL retire out %0d: fo_valid=%b one_hot=%h expected 0/0", k, fo_valid, one_hot_FO);
      end
      if (k == N - 1) begin
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || fo_last !== 1'b0) begin
          errors++;
          $display("FAIL batch_end: in_ready=%b busy=%b fo_last=%b expected 1/0/0", in_ready, busy, fo_last);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (in_ready !== 1'b1 || fo_valid !== 1'b0 || one_hot_FO !== '0 ||
        fo_data !== '0 || fo_last !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: in_ready=%b fo_valid=%b one_hot=%h fo_data=%h fo_last=%b busy=%b expected 1/0/0/0/0/0",
               tag, in_ready, fo_valid, one_hot_FO, fo_data, fo_last, busy);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    fo_ready = 1'b0;
    #2;
    check_reset_outputs("reset_async");
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("reset_release");
  endtask

  task automatic test_spec_vector();
    logic [W-1:0] v [N] = '{15, 3, 200, 7, 0, 99, 1, 2, 8, 4, 5, 6, 9, 10, 11, 12};
    for (int i = 0; i < N; i++) batch[i] = v[i];
    load_batch(1'b0);
    drain(0, N);
  endtask

  task automatic test_equal_values();
    for (int i = 0; i < N; i++) batch[i] = 8'h55;
    load_batch(1'b0);
    drain(0, N);
  endtask

  task automatic test_descending();
    for (int i = 0; i < N; i++) batch[i] = W'(8'hFF - i);
    load_batch(1'b0);
    drain(0, N);
  endtask

  task automatic test_backpressure();
    int cnt;
    logic [N-1:0] oh_snap;
    logic [W-1:0] d_snap;
    for (int i = 0; i < N; i++) batch[i] = W'($urandom);
    load_batch(1'b0);
    fo_ready = 1'b0;
    cnt = 0;
    while (fo_valid !== 1'b1 && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    checks++;
    if (cnt != W) begin
      errors++;
      $display("FAIL bp_latency: %0d edges expected %0d", cnt, W);
    end
    oh_snap = one_hot_FO;
    d_snap  = fo_data;
    checks++;
    if (oh_snap !== (N'(1) << order[0]) || d_snap !== batch[order[0]]) begin
      errors++;
      $display("FAIL bp_first: one_hot=%h data=%0d expected %h/%0d",
               oh_snap, d_snap, N'(1) << order[0], batch[order[0]]);
    end
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (fo_valid !== 1'b1 || busy !== 1'b1 || one_hot_FO !== oh_snap || fo_data !== d_snap) begin
        errors++;
        $display("FAIL bp_hold: fo_valid=%b busy=%b one_hot=%h data=%0d expected 1/1/%h/%0d",
                 fo_valid, busy, one_hot_FO, fo_data, oh_snap, d_snap);
      end
    end
    fo_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (fo_valid !== 1'b0 || one_hot_FO !== '0) begin
      errors++;
      $display("FAIL bp_release: fo_valid=%b one_hot=%h expected 0/0", fo_valid, one_hot_FO);
    end
    drain(1, N);
  endtask

  task automatic test_reset_mid_scan();
    for (int i = 0; i < N; i++) batch[i] = W'($urandom);
    load_batch(1'b0);
    drain(0, 7);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midscan_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midscan_release");
    for (int i = 0; i < N; i++) batch[i] = W'($urandom_range(0, 63));
    load_batch(1'b0);
    drain(0, N);
  endtask

  task automatic test_in_valid_random();
    for (int i = 0; i < N; i++) batch[i] = W'($urandom);
    load_batch(1'b1);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    drain(0, N);
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) batch[i] = W'($urandom_range(0, 3));
    load_batch(1'b1);
    drain(0, N);
  endtask

  task automatic test_random_batches();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < N; i++)
        batch[i] = (b % 2 == 0) ? W'($urandom) : W'($urandom_range(250, 255));
      load_batch(b[0]);
      drain(0, N);
    end
  endtask

  initial begin
    test_reset();
    test_spec_vector();
    test_equal_values();
    test_descending();
    test_backpressure();
    test_reset_mid_scan();
    test_in_valid_random();
    test_random_batches();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/msb_scan_filter.md
Name: msb_scan_filter

Overview:
- Upstream stage of the largest-element detector in the comparison-free sorting engine.
- Loads ELEMENT_NUM unsigned elements, then repeatedly scans bit columns from MSB to LSB across all still-alive elements, narrowing a candidate mask until only the largest remains.
- Presents that mask as a strictly one-hot vector (one_hot_FO), which feeds the detector directly, together with the element value.
- On each output handshake it retires the emitted element and starts the next scan; elements therefore leave in descending order.

Parameters:
- ELEMENT_NUM, 16, number of elements per sort batch (shared macro `ELEMENT_NUM).
- LOG2_ELEMENT_NUM, 4, width of element index and counters (shared macro `LOG2_ELEMENT_NUM).
- DATA_WIDTH, 8, element width in bits (shared macro `DATA_WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  load data valid.
- in_ready  out  1  high only in LOAD.
- in_data  in  DATA_WIDTH  element value; element k is the k-th accepted beat.
- fo_valid  out  1  one_hot_FO/fo_data valid; high only in PRESENT.
- fo_ready  in  1  downstream accepts.
- one_hot_FO  out  ELEMENT_NUM  exactly one bit set when fo_valid; bit i selects element i.
- fo_data  out  DATA_WIDTH  value of selected element.
- fo_last  out  1  high with fo_valid on the final element of the batch.
- busy  out  1  high in SCAN or PRESENT.

Behaviour:
- Reset (async, any state): state=LOAD, wr_ptr=0, out_cnt=0, alive=0, cand=0, bit_idx=DATA_WIDTH-1. Outputs: in_ready=1, fo_valid=0, one_hot_FO=0, fo_data=0, fo_last=0, busy=0. Storage contents are don't-care. Reset mid-sort abandons the batch.
- LOAD:
  - On each in_valid&in_ready edge: elem[wr_ptr]<=in_data; wr_ptr++.
  - On the accept with wr_ptr==ELEMENT_NUM-1: wr_ptr<=0, alive<=all ones, cand<=all ones, bit_idx<=DATA_WIDTH-1, out_cnt<=0, go SCAN.
- SCAN (exactly DATA_WIDTH cycles, fixed latency, no early exit):
  - col[i] = cand[i] & elem[i][bit_idx].
  - If col!=0 then cand<=col, else cand unchanged.
  - bit_idx decrements each cycle.
  - In the bit_idx==0 cycle: final = (col!=0 ? col : cand). Register one_hot_FO <= lowest set bit of final (tie-break to lowest index, so duplicates still yield exactly one-hot). Register fo_data <= elem[that index], fo_last <= (out_cnt==ELEMENT_NUM-1). Go PRESENT.
- Latency: fo_valid rises DATA_WIDTH rising edges after the entering edge (the final load accept or the previous output handshake).
- PRESENT:
  - fo_valid=1. one_hot_FO, fo_data and fo_last stay stable until handshake.
  - On fo_ready: alive <= alive & ~one_hot_FO; out_cnt++; fo_valid, one_hot_FO and fo_last drop next cycle.
    - If fo_last: go LOAD with alive=0.
    - Else: cand <= updated alive, bit_idx <= DATA_WIDTH-1, go SCAN.
  - fo_ready while fo_valid=0 is ignored.
- Invariant: cand is a subset of alive at all times; one_hot_FO has popcount 1 when fo_valid and is 0 otherwise.
- Throughput: one element per DATA_WIDTH+1 cycles when fo_ready is held high.
- in_valid outside LOAD is ignored; no input data is lost, since in_ready=0 outside LOAD.

Decomposition:
- ELEMENT_NUM, LOG2_ELEMENT_NUM and DATA_WIDTH live in the shared parameter include used across the engine.
- State encoding (LOAD/SCAN/PRESENT) is local to the block.
- One sub-module: lowest_one_isolate (combinational, ELEMENT_NUM wide, out = v & (~v+1)), reused for the tie-break and available to other stages.

Test Plan:
- Load 15,3,200,7,0,99,1,2,8,4,5,6,9,10,11,12 (indices 0..15), fo_ready=1 -> first one_hot_FO=16'h0004, fo_data=200 at the 8th edge after the last load; then 16'h0020/99, 16'h0001/15, and so on down to 16'h0010/0 with fo_last=1; in_ready=1 the next cycle.
- All 16 elements = 8'h55 -> one_hot_FO emits 16'h0001, 16'h0002, ..., 16'h8000 in order; every fo_data = 8'h55.
- Backpressure: hold fo_ready=0 for 5 cycles in PRESENT -> one_hot_FO/fo_data held stable, fo_valid stays 1, no new scan starts; release -> exactly one element retired.
- Elements 0..15 with values 8'hFF,8'hFE,...,8'hF0 -> outputs idx 0,1,...,15; each fo_valid pulse spaced 9 cycles apart with fo_ready=1.
- Deassert rst_n mid-SCAN after the 7th element is emitted -> all outputs at reset values immediately; a fresh 16-beat load then sorts correctly with no residue from the old batch.
- in_valid toggled randomly during LOAD, and held high during SCAN/PRESENT -> exactly 16 beats captured; beats presented outside LOAD are not consumed.
